// File: rtl/noc_inject_arbiter.sv
// Round-robin arbiter sharing one ring injection slot among NREQ requesters.
// Latency 1 cycle req_ready->out_valid; slot refills on the same edge it drains.
module noc_inject_arbiter #(
  parameter int PWIDTH = 47,
  parameter int NREQ   = 4,
  parameter int CWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*PWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  output logic [PWIDTH-1:0]        out_data,
  input  logic                     out_ready,
  output logic [NREQ*CWIDTH-1:0]   grant_cnt,
  output logic                     busy
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0]   ptr;
  logic [PTRW-1:0]   winner;
  logic              found;
  logic              free;
  logic              xfer;
  logic [CWIDTH-1:0] cnt [NREQ];

  function automatic logic [PTRW-1:0] wrap_idx(input logic [PTRW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return PTRW'(s);
  endfunction

  assign free = !out_valid || out_ready;

  // Search starts at ptr so the requester after the last winner has priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[wrap_idx(ptr, k)]) begin
        found  = 1'b1;
        winner = wrap_idx(ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && en && free && found) req_ready[winner] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);
  assign busy = out_valid || (|req_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= req_data[int'(winner)*PWIDTH +: PWIDTH];
      ptr       <= wrap_idx(winner, 1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (req_valid[i] && req_ready[i] && (cnt[i] != {CWIDTH{1'b1}})) begin
        cnt[i] <= cnt[i] + CWIDTH'(1);
      end
    end
    assign grant_cnt[i*CWIDTH +: CWIDTH] = cnt[i];
  end

endmodule
